// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU and its shift-add multiplier.
package alu_pkg;

    localparam int ALU_N       = 8;
    localparam int ALU_OP_SIZE = 2;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MUL  = 2'd2,
        OP_PASS = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Signed radix-2 shift-add multiplier: one add/subtract per cycle for N cycles,
// exposing the upper half of the 2N-bit product alongside the done flag.
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int N = ALU_N
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] prod_hi
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N:0]    acc;
    logic [N-1:0]  mplr;
    logic [N-1:0]  mcand;
    logic [CW-1:0] cnt;
    logic          run;

    logic          sub;
    logic [N:0]    addend;
    logic [N:0]    sum;

    // The final step weighs the multiplier's sign bit, so it subtracts instead
    // of adding; the subtract reuses the same adder via invert plus carry-in.
    always_comb begin
        sub    = mplr[0] && (cnt == '0);
        addend = mplr[0] ? {mcand[N-1], mcand} : '0;
        sum    = acc + (addend ^ {(N+1){sub}}) + {{N{1'b0}}, sub};
    end

    assign done    = run && (cnt == '0);
    assign prod_hi = sum[N:1];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            acc   <= '0;
            mplr  <= '0;
            mcand <= '0;
            cnt   <= '0;
            run   <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            mplr  <= b;
            mcand <= a;
            cnt   <= CW'(N - 1);
            run   <= 1'b1;
        end else if (run) begin
            acc  <= {sum[N], sum[N:1]};
            mplr <= mplr >> 1;
            if (cnt == '0) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/PASS, N-cycle signed MUL (upper half),
// registered result with a one-cycle write strobe toward the register file.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepts start; ADD/SUB/PASS complete here in one edge
// MUL    | shift-add multiplier iterating, start ignored
// DONE   | product written (writeEnable high), start ignored
module seq_alu
    import alu_pkg::*;
#(
    parameter int N       = ALU_N,
    parameter int OP_SIZE = ALU_OP_SIZE
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               start,
    input  logic [OP_SIZE-1:0] op,
    input  logic [N-1:0]       aIn,
    input  logic [N-1:0]       bIn,
    output logic [N-1:0]       result,
    output logic               writeEnable,
    output logic               busy,
    output logic               zero
);

    alu_state_t   state;
    alu_state_t   state_nxt;
    logic         mul_load;
    logic         mul_done;
    logic [N-1:0] mul_prod;
    logic         res_load;
    logic [N-1:0] res_nxt;

    // Anything that is not ADD/SUB decodes as PASS, including codes above 3.
    function automatic logic [N-1:0] alu_1c(input logic [OP_SIZE-1:0] code,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        if (code == OP_SIZE'(OP_ADD)) begin
            return a + b;
        end else if (code == OP_SIZE'(OP_SUB)) begin
            return a - b;
        end else begin
            return a;
        end
    endfunction

    shift_add_mul #(.N(N)) u_mul (
        .clk     (clk),
        .nReset  (nReset),
        .load    (mul_load),
        .a       (aIn),
        .b       (bIn),
        .done    (mul_done),
        .prod_hi (mul_prod)
    );

    always_comb begin
        state_nxt = state;
        mul_load  = 1'b0;
        res_load  = 1'b0;
        res_nxt   = result;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_SIZE'(OP_MUL)) begin
                        mul_load  = 1'b1;
                        state_nxt = S_MUL;
                    end else begin
                        res_load = 1'b1;
                        res_nxt  = alu_1c(op, aIn, bIn);
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    res_load  = 1'b1;
                    res_nxt   = mul_prod;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state       <= S_IDLE;
            result      <= '0;
            zero        <= 1'b0;
            writeEnable <= 1'b0;
        end else begin
            state       <= state_nxt;
            writeEnable <= res_load;
            if (res_load) begin
                result <= res_nxt;
                zero   <= (res_nxt == '0);
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         nReset;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] aIn;
    logic [N-1:0] bIn;
    logic [N-1:0] result;
    logic         writeEnable;
    logic         busy;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.N(N), .OP_SIZE(2)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .start       (start),
        .op          (op),
        .aIn         (aIn),
        .bIn         (bIn),
        .result      (result),
        .writeEnable (writeEnable),
        .busy        (busy),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        int p;
        int q;
        case (o)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                p = int'($signed(a)) * int'($signed(b));
                q = p >>> N;
                return q[N-1:0];
            end
            default: return a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit noise, input string tag);
        logic [N-1:0] exp;
        exp   = model(o, a, b);
        op    = o;
        aIn   = a;
        bIn   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (o == 2'd2) begin
            for (int j = 0; j <= N; j++) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy j=%0d got %b want 1", tag, j, busy);
                end
                n_checks++;
                if (writeEnable !== (j == N)) begin
                    n_fail++;
                    $display("FAIL %s we j=%0d got %b want %b", tag, j, writeEnable, (j == N));
                end
                if (j == N) begin
                    n_checks++;
                    if (result !== exp || zero !== (exp == '0)) begin
                        n_fail++;
                        $display("FAIL %s mul result got %h/z%b want %h/z%b", tag, result, zero,
                                 exp, (exp == '0));
                    end
                end
                if (noise) begin
                    aIn   = N'($urandom);
                    bIn   = N'($urandom);
                    op    = 2'($urandom_range(0, 3));
                    start = 1'($urandom_range(0, 1));
                end
                if (j < N) tick();
            end
            tick();
            start = 1'b0;
            n_checks++;
            if (busy !== 1'b0 || writeEnable !== 1'b0 || result !== exp) begin
                n_fail++;
                $display("FAIL %s after done got busy%b we%b %h want 0 0 %h", tag, busy,
                         writeEnable, result, exp);
            end
        end else begin
            n_checks++;
            if (writeEnable !== 1'b1 || busy !== 1'b0 || result !== exp || zero !== (exp == '0)) begin
                n_fail++;
                $display("FAIL %s 1c got we%b busy%b %h z%b want we1 busy0 %h z%b", tag,
                         writeEnable, busy, result, zero, exp, (exp == '0));
            end
            aIn = ~a;
            tick();
            n_checks++;
            if (writeEnable !== 1'b0 || result !== exp) begin
                n_fail++;
                $display("FAIL %s hold got we%b %h want we0 %h", tag, writeEnable, result, exp);
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        start  = 1'b1;
        op     = 2'd0;
        aIn    = 8'h03;
        bIn    = 8'h04;
        #3;
        n_checks++;
        if (result !== '0 || writeEnable !== 1'b0 || busy !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got %h we%b busy%b z%b want 00 0 0 0", result, writeEnable,
                     busy, zero);
        end
        tick();
        tick();
        n_checks++;
        if (writeEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_we got %b want 0", writeEnable);
        end
        nReset = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (writeEnable !== 1'b1 || result !== 8'h07) begin
            n_fail++;
            $display("FAIL first_start got we%b %h want we1 07", writeEnable, result);
        end
        tick();
    endtask

    task automatic test_directed();
        do_op(2'd0, 8'hFF, 8'h01, 1'b0, "add_wrap");
        do_op(2'd1, 8'h00, 8'h01, 1'b0, "sub_wrap");
        do_op(2'd3, 8'hA5, 8'h3C, 1'b0, "pass");
        do_op(2'd2, 8'h40, 8'h40, 1'b0, "mul_40_40");
        do_op(2'd2, 8'h80, 8'h80, 1'b0, "mul_80_80");
        do_op(2'd2, 8'h80, 8'h7F, 1'b0, "mul_80_7f");
        do_op(2'd2, 8'h00, 8'h9C, 1'b1, "mul_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), N'($urandom), N'($urandom),
                  1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   o;
        logic [N-1:0] exp;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0: o = 2'd0;
                1: o = 2'd1;
                default: o = 2'd3;
            endcase
            op    = o;
            aIn   = N'($urandom);
            bIn   = N'($urandom);
            start = 1'b1;
            exp   = model(o, aIn, bIn);
            tick();
            n_checks++;
            if (writeEnable !== 1'b1 || result !== exp) begin
                n_fail++;
                $display("FAIL b2b i=%0d got we%b %h want we1 %h", i, writeEnable, result, exp);
            end
        end
        start = 1'b0;
        tick();
        n_checks++;
        if (writeEnable !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end we got %b want 0", writeEnable);
        end
    endtask

    task automatic test_busy_ignore();
        logic [N-1:0] exp;
        exp   = model(2'd2, 8'h33, 8'hD7);
        op    = 2'd2;
        aIn   = 8'h33;
        bIn   = 8'hD7;
        start = 1'b1;
        tick();
        op  = 2'd0;
        aIn = 8'h11;
        bIn = 8'h22;
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (writeEnable !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ign we j=%0d got %b want 0", j, writeEnable);
            end
            tick();
        end
        n_checks++;
        if (writeEnable !== 1'b1 || result !== exp) begin
            n_fail++;
            $display("FAIL busy_ign mul got we%b %h want we1 %h", writeEnable, result, exp);
        end
        tick();
        n_checks++;
        if (writeEnable !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ign done_start got we%b busy%b want 0 0", writeEnable, busy);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (writeEnable !== 1'b1 || result !== 8'h33) begin
            n_fail++;
            $display("FAIL busy_ign idle_add got we%b %h want we1 33", writeEnable, result);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        do_op(2'd0, 8'h05, 8'h06, 1'b0, "pre_rst");
        op    = 2'd2;
        aIn   = 8'h7F;
        bIn   = 8'h7F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        nReset = 1'b0;
        #1;
        n_checks++;
        if (result !== '0 || writeEnable !== 1'b0 || busy !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid async got %h we%b busy%b z%b want 00 0 0 0", result,
                     writeEnable, busy, zero);
        end
        tick();
        nReset = 1'b1;
        for (int j = 0; j < N + 3; j++) begin
            tick();
            n_checks++;
            if (writeEnable !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid post j=%0d got we%b busy%b want 0 0", j, writeEnable, busy);
            end
        end
        do_op(2'd0, 8'h12, 8'h34, 1'b0, "post_rst_add");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
